// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller with branch/trap PC redirect
module pipe_ctrl #(
  parameter int PC_W = 12,
  parameter int TIMEOUT = 16,
  parameter logic [PC_W-1:0] TRAP_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_id,
  input  logic            stallreq_ex,
  input  logic            stallreq_mem,
  input  logic            branch_i,
  input  logic [PC_W-1:0] branch_pc_i,
  output logic [5:0]      stall_o,
  output logic [5:0]      flash_o,
  output logic            pc_load_o,
  output logic [PC_W-1:0] pc_target_o,
  output logic            trap_o,
  output logic [15:0]     stall_cycles_o
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic {RUN, REFILL} st_t;
  st_t r_st;
  logic            r_pend_v;
  logic [PC_W-1:0] r_pend_pc;
  logic [CW-1:0]   r_wait_cnt;
  logic            w_trap;
  logic            w_held;
  assign w_trap = stallreq_mem && (r_wait_cnt == CW'(TIMEOUT - 1));
  assign w_held = stallreq_mem || stallreq_ex;
  // priority-ordered request decode; everything is silenced while in reset
  always_comb begin
    stall_o = '0;
    flash_o = '0;
    pc_load_o = 1'b0;
    pc_target_o = '0;
    trap_o = 1'b0;
    if (!rst) begin
      if (w_trap) begin
        flash_o = 6'b011110;
        pc_load_o = 1'b1;
        pc_target_o = TRAP_VEC;
        trap_o = 1'b1;
      end else if (stallreq_mem) begin
        stall_o = 6'b011111;
      end else if (stallreq_ex) begin
        stall_o = 6'b001111;
      end else if (r_pend_v || branch_i) begin
        flash_o = 6'b000110;
        pc_load_o = 1'b1;
        pc_target_o = r_pend_v ? r_pend_pc : branch_pc_i;
      end else if (r_st == REFILL) begin
        flash_o = 6'b000010;
      end else if (stallreq_id) begin
        stall_o = 6'b000111;
      end
    end
  end
  // redirect bookkeeping, memory-wait timeout and stall statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= RUN;
      r_pend_v <= 1'b0;
      r_pend_pc <= '0;
      r_wait_cnt <= '0;
      stall_cycles_o <= '0;
    end else begin
      r_wait_cnt <= (stallreq_mem && !w_trap) ? r_wait_cnt + 1'b1 : '0;
      if (stall_o[0] && stall_cycles_o != 16'hFFFF)
        stall_cycles_o <= stall_cycles_o + 16'd1;
      if (w_trap) begin
        r_pend_v <= 1'b0;
        r_st <= REFILL;
      end else if (w_held) begin
        if (branch_i) begin
          r_pend_v <= 1'b1;
          r_pend_pc <= branch_pc_i;
        end
      end else if (r_pend_v) begin
        r_pend_v <= branch_i;
        if (branch_i)
          r_pend_pc <= branch_pc_i;
        r_st <= REFILL;
      end else if (branch_i) begin
        r_st <= REFILL;
      end else if (r_st == REFILL) begin
        r_st <= RUN;
      end
    end
  end
endmodule
